// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding, oversample default, baud divider helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam int OSR_DEF = 16;

  // Integer floor: the actual bit rate ends up slightly fast when the ratio is not exact.
  function automatic int calc_clk_div(input int fqr, input int baud_rate, input int osr);
    return fqr / (baud_rate * osr);
  endfunction

endpackage

// File: rtl/baud_tick_rx.sv
// Oversample tick generator: one-cycle enable every CLK_DIV clk1 cycles.
// restart zeroes the count so the following tick lands exactly CLK_DIV cycles later.
module baud_tick_rx #(
  parameter int CLK_DIV = 27
) (
  input  logic clk1,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (restart || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign tick = !restart && (r_cnt == LAST);

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 16x-oversampled UART RX with mid-bit sampling; UART_RX_MAJORITY_EN selects 2-of-3 voting.
// rx_valid pulses one clk1 after the mid-stop sample; no backpressure, each word overwrites data_out.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int Data_length = 8,
  parameter int parity_en   = 0,
  parameter int fqr         = 50000000,
  parameter int baud_rate   = 115200,
  parameter int OSR         = OSR_DEF
) (
  input  logic                   clk1,
  input  logic                   rst,
  input  logic                   serialdata_in,
  input  logic                   parity_type,
  output logic [Data_length-1:0] data_out,
  output logic                   rx_valid,
  output logic                   parity_err,
  output logic                   frame_err,
  output logic                   rx_busy
);

  localparam int CLK_DIV = calc_clk_div(fqr, baud_rate, OSR);
  localparam int TW      = $clog2(OSR);
  localparam int BW      = $clog2(Data_length);
`ifdef UART_RX_MAJORITY_EN
  localparam int SAMPLE_T = OSR / 2;
`else
  localparam int SAMPLE_T = OSR / 2 - 1;
`endif
  localparam logic [TW-1:0] T_SAMP = TW'(SAMPLE_T);
  localparam logic [TW-1:0] T_LAST = TW'(OSR - 1);
  localparam logic [BW-1:0] B_LAST = BW'(Data_length - 1);

  uart_state_t            r_state, w_next;
  logic [1:0]             r_sync;
  logic                   r_rxs_d, r_armed, r_ptype, r_perr;
  logic [TW-1:0]          r_tcnt;
  logic [BW-1:0]          r_bcnt;
  logic [Data_length-1:0] r_shift;
  logic                   w_rxs, w_tick, w_start, w_samp, w_bit;

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) r_sync <= 2'b11;
    else     r_sync <= {r_sync[0], serialdata_in};
  end

  assign w_rxs   = r_sync[1];
  assign w_start = (r_state == IDLE) && r_armed && r_rxs_d && !w_rxs;
  assign w_samp  = w_tick && (r_tcnt == T_SAMP) && (r_state != IDLE);
  assign rx_busy = (r_state != IDLE);

  baud_tick_rx #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk1    (clk1),
    .rst     (rst),
    .restart (w_start),
    .tick    (w_tick)
  );

`ifdef UART_RX_MAJORITY_EN
  logic r_s_a, r_s_b;

  // The two ticks before the decision tick feed the vote together with the live sample.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      r_s_a <= 1'b1;
      r_s_b <= 1'b1;
    end else if (w_tick) begin
      if (r_tcnt == TW'(SAMPLE_T - 2)) r_s_a <= w_rxs;
      if (r_tcnt == TW'(SAMPLE_T - 1)) r_s_b <= w_rxs;
    end
  end

  assign w_bit = (r_s_a & r_s_b) | (r_s_a & w_rxs) | (r_s_b & w_rxs);
`else
  assign w_bit = w_rxs;
`endif

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next = START;
      START:   if (w_samp) w_next = w_bit ? IDLE : DATA;
      DATA:    if (w_samp && (r_bcnt == B_LAST)) w_next = (parity_en != 0) ? PARITY : STOP;
      PARITY:  if (w_samp) w_next = STOP;
      STOP:    if (w_samp) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      r_rxs_d    <= 1'b1;
      r_armed    <= 1'b0;
      r_ptype    <= 1'b0;
      r_perr     <= 1'b0;
      r_tcnt     <= '0;
      r_bcnt     <= '0;
      r_shift    <= '0;
      data_out   <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      r_rxs_d  <= w_rxs;
      rx_valid <= 1'b0;
      // Arming needs a full tick of idle-high, which keeps a held-low break from retriggering.
      if (w_start) begin
        r_armed <= 1'b0;
        r_ptype <= parity_type;
        r_tcnt  <= '0;
        r_bcnt  <= '0;
      end else if (r_state == IDLE) begin
        r_tcnt <= '0;
        if (w_tick && w_rxs) r_armed <= 1'b1;
      end else if (w_tick) begin
        r_tcnt <= (r_tcnt == T_LAST) ? '0 : r_tcnt + TW'(1);
      end
      if (w_samp) begin
        case (r_state)
          DATA: begin
            r_shift[r_bcnt] <= w_bit;
            r_bcnt          <= (r_bcnt == B_LAST) ? '0 : r_bcnt + BW'(1);
          end
          PARITY: r_perr <= w_bit ^ (^r_shift) ^ r_ptype;
          STOP: begin
            data_out   <= r_shift;
            parity_err <= (parity_en != 0) && r_perr;
            frame_err  <= ~w_bit;
            rx_valid   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receiver; the receive-side counterpart of the existing UART transmitter.
- Frame format: 1 start bit (0), Data_length data bits LSB first, optional parity bit, 1 stop bit (1). Idle line is 1.
- The serial input is asynchronous. It is synchronised, then sampled at 16x oversampling and checked mid-bit.
- Delivers each word with a one-cycle valid pulse plus parity and framing error flags.

Parameters:
- Data_length, 8, number of data bits per frame (5..9).
- parity_en, 0, 1 = a parity bit follows the data; 0 = no parity bit.
- fqr, 50000000, clk1 frequency in Hz.
- baud_rate, 115200, line bit rate.
- OSR, 16, oversample ticks per bit.

Ports:
- clk1  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- serialdata_in  in  1  asynchronous serial line
- parity_type  in  1  0 = even parity (bit = ^data), 1 = odd parity (bit = ~^data); captured at start detect
- data_out  out  Data_length  last received word; held until the next rx_valid
- rx_valid  out  1  one-clk1 pulse when a frame completes
- parity_err  out  1  parity mismatch for the frame flagged by rx_valid; held with data_out
- frame_err  out  1  stop bit sampled as 0; held with data_out
- rx_busy  out  1  high from start detect until the stop sample

Behaviour:
- Clock and reset: one clock, clk1. Reset is asynchronous and active-high on rst.
- Reset values: data_out=0, rx_valid=0, parity_err=0, frame_err=0, rx_busy=0, state=IDLE, synchroniser flops=1, counters=0.
- Synchroniser: 2-flop synchroniser on serialdata_in; all logic uses the synchronised value rxs.
- Tick generator: tick is a single-cycle clock enable every CLK_DIV=fqr/(baud_rate*OSR) clk1 cycles (integer floor; 27 at defaults).
  - The counter restarts at 0 on start detect so sampling is phase-aligned to the falling edge.
  - No derived clocks anywhere in the block.
- Bit timing:
  - tcnt counts ticks 0..OSR-1 within a bit.
  - The sample point is tcnt==OSR/2-1 (7).
  - bcnt counts data bits 0..Data_length-1.
- State machine:
  - IDLE: armed only after rxs has been 1 for at least one tick. A falling edge of rxs goes to START, sets rx_busy, and latches parity_type.
  - START: at the sample point, rxs=1 is a false start: return to IDLE, rx_busy=0, no flags. rxs=0 moves to DATA and tcnt wraps on bit boundaries from here.
  - DATA: at each sample point, shift rxs into the shift register at bit bcnt. After bit Data_length-1, go to PARITY if parity_en, else STOP.
  - PARITY: sample the parity bit and compare with the expected value from the latched parity_type.
  - STOP: at the sample point, load data_out, parity_err (0 when parity_en=0) and frame_err=~rxs. Pulse rx_valid on the next clk1 edge, clear rx_busy, go to IDLE.
- Back-to-back frames: leaving at the mid-stop sample gives half a bit of margin, so consecutive frames with no idle gap are received.
- Break/framing error: if rxs is still 0 after a frame_err, IDLE stays disarmed until rxs returns to 1. No spurious frame is produced.
- Latency: rx_valid rises 1 clk1 cycle after the stop-bit sample, i.e. about (1+Data_length+parity_en+0.5) bit times plus 2 sync cycles after the start edge.
- Reset mid-frame: abort immediately to reset values; the partial word is discarded and rx_valid never pulses.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each bit value is the 2-of-3 majority of rxs at ticks 6, 7 and 8. The START false-start check also uses the majority.
- Undefined: a single sample at tick 7. Port list and timing are identical in both builds.

Decomposition:
- Package uart_pkg:
  - state enum: IDLE, START, DATA, PARITY, STOP
  - OSR default
  - function calc_clk_div(fqr, baud_rate, OSR)
  - shared with the transmitter
- Sub-module baud_tick_rx: clk1, rst, restart in; tick out (one-cycle enable). CLK_DIV is a parameter.

Test Plan:
- 8N1 at defaults: send 0xA5 at 434 clk1 per bit (+0.5% skew) -> one rx_valid pulse, data_out=0xA5, parity_err=0, frame_err=0.
- parity_en=1, parity_type=0: send 0x37 with parity bit 1 -> parity_err=0. Repeat with parity bit 0 -> parity_err=1, data_out=0x37.
- Glitch: 3-bit-tick (81 clk1) low pulse on an idle line -> no rx_valid, rx_busy returns to 0, next frame 0x5A received correctly.
- Framing/break: send 0xFF with stop=0, then hold the line 0 for 20 bit times -> one rx_valid with frame_err=1, then no further frames until the line rises. A following frame 0x01 is received cleanly.
- Back-to-back: 0x00, 0xFF, 0x81 with zero idle gap -> three rx_valid pulses, words in order, no errors.
- Reset mid-DATA: assert rst during bit 4 of 0xC3 -> outputs at reset values, no rx_valid. The next full frame 0x3C is received correctly.
